// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA configuration path.
// Frame field positions describe the PE instruction layout; the sequencer treats frames as opaque.
package cgra_pkg;

    localparam int FRAME_W = 64;

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_RUN,
        CFG_DONE
    } cfg_seq_state_t;

    localparam int OP_LO        = 0;
    localparam int OP_HI        = 5;
    localparam int SRC0_LO      = 6;
    localparam int SRC0_HI      = 9;
    localparam int SRC1_LO      = 10;
    localparam int SRC1_HI      = 13;
    localparam int DST_LO       = 14;
    localparam int DST_HI       = 17;
    localparam int ROUTE_LO     = 18;
    localparam int ROUTE_HI     = 21;
    localparam int PRED_EN_BIT  = 22;
    localparam int PRED_INV_BIT = 23;
    localparam int IMM_LO       = 24;
    localparam int IMM_HI       = 39;

    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_MUL   = 6'h03;
    localparam logic [5:0] OP_PASS0 = 6'h08;

endpackage

// File: rtl/cgra_ctx_store.sv
// Context frame register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; slots are undefined until the host writes them.
module cgra_ctx_store #(
    parameter int W     = 64,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Replays preloaded context frames into one PE config port, looping the frame list
// (loop_count+1) times at one frame per un-stalled cycle.
module cgra_cfg_sequencer import cgra_pkg::*; #(
    parameter int FRAME_W   = cgra_pkg::FRAME_W,
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = $clog2(CTX_DEPTH),
    parameter int LOOP_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [CTX_AW-1:0]  wr_addr_i,
    input  logic [FRAME_W-1:0] wr_data_i,
    input  logic               start_i,
    input  logic [CTX_AW:0]    ctx_count_i,
    input  logic [LOOP_W-1:0]  loop_count_i,
    input  logic               stall_i,
    input  logic               abort_i,
    output logic [FRAME_W-1:0] config_frame_o,
    output logic               config_valid_o,
    output logic [CTX_AW-1:0]  ctx_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               wr_err_o
);

    cfg_seq_state_t     state_q;
    logic [CTX_AW-1:0]  idx_q;
    logic [CTX_AW:0]    len_q;
    logic [LOOP_W-1:0]  loops_q;
    logic               last_q;
    logic [FRAME_W-1:0] config_frame_q;
    logic               config_valid_q;
    logic [CTX_AW-1:0]  ctx_idx_q;
    logic               done_q;
    logic               wr_err_q;

    logic               in_idle;
    logic               wr_accept;
    logic [CTX_AW:0]    start_len;
    logic [CTX_AW:0]    src_len;
    logic [LOOP_W-1:0]  src_loops;
    logic [CTX_AW-1:0]  src_idx;
    logic               at_end;
    logic               issue;
    logic [FRAME_W-1:0] store_rdata;
    logic [FRAME_W-1:0] rd_data;

    assign in_idle   = (state_q == CFG_IDLE);
    assign wr_accept = wr_en_i && in_idle;
    assign start_len = (ctx_count_i > (CTX_AW+1)'(CTX_DEPTH)) ? (CTX_AW+1)'(CTX_DEPTH) : ctx_count_i;

    // Frame 0 is issued on the start edge itself, so in IDLE the issue path works
    // from the values about to be latched rather than from the registers.
    assign src_len   = in_idle ? start_len    : len_q;
    assign src_loops = in_idle ? loop_count_i : loops_q;
    assign src_idx   = in_idle ? '0           : idx_q;
    assign at_end    = ({1'b0, src_idx} == (src_len - (CTX_AW+1)'(1)));

    assign issue = !stall_i &&
                   ((in_idle && start_i && (ctx_count_i != '0)) ||
                    ((state_q == CFG_RUN) && !abort_i && !last_q));

    cgra_ctx_store #(
        .W     (FRAME_W),
        .DEPTH (CTX_DEPTH),
        .AW    (CTX_AW)
    ) u_store (
        .clk     (clk),
        .we_i    (wr_accept),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (src_idx),
        .rdata_o (store_rdata)
    );

    // A write landing on the start edge must be visible to the first read.
    assign rd_data = (wr_accept && (wr_addr_i == src_idx)) ? wr_data_i : store_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CFG_IDLE;
            idx_q          <= '0;
            len_q          <= '0;
            loops_q        <= '0;
            last_q         <= 1'b0;
            config_frame_q <= '0;
            config_valid_q <= 1'b0;
            ctx_idx_q      <= '0;
            done_q         <= 1'b0;
            wr_err_q       <= 1'b0;
        end else begin
            config_valid_q <= 1'b0;
            done_q         <= 1'b0;
            wr_err_q       <= wr_en_i && !in_idle;

            case (state_q)
                CFG_IDLE: begin
                    if (start_i) begin
                        if (ctx_count_i == '0) begin
                            state_q <= CFG_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CFG_RUN;
                            len_q   <= start_len;
                            loops_q <= loop_count_i;
                            idx_q   <= '0;
                        end
                    end
                end
                CFG_RUN: begin
                    if (abort_i) begin
                        state_q <= CFG_IDLE;
                        last_q  <= 1'b0;
                    end else if (last_q) begin
                        state_q <= CFG_DONE;
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= CFG_IDLE;
                end
            endcase

            // Placed after the state case so advance values override the start-edge latch.
            if (issue) begin
                config_valid_q <= 1'b1;
                config_frame_q <= rd_data;
                ctx_idx_q      <= src_idx;
                if (!at_end) begin
                    idx_q <= src_idx + CTX_AW'(1);
                end else if (src_loops != '0) begin
                    idx_q   <= '0;
                    loops_q <= src_loops - LOOP_W'(1);
                end else begin
                    last_q <= 1'b1;
                end
            end
        end
    end

    assign config_frame_o = config_frame_q;
    assign config_valid_o = config_valid_q;
    assign ctx_idx_o      = ctx_idx_q;
    assign busy_o         = (state_q == CFG_RUN);
    assign done_o         = done_q;
    assign wr_err_o       = wr_err_q;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Self-checking bench for cgra_cfg_sequencer: issued frames are scoreboarded,
// timing of valid/done/busy is checked per scenario.
module tb_cgra_cfg_sequencer;
    import cgra_pkg::*;

    localparam int CTX_DEPTH = 16;
    localparam int CTX_AW    = 4;
    localparam int LOOP_W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en_i = 1'b0;
    logic [CTX_AW-1:0] wr_addr_i = '0;
    logic [63:0]       wr_data_i = '0;
    logic              start_i = 1'b0;
    logic [CTX_AW:0]   ctx_count_i = '0;
    logic [LOOP_W-1:0] loop_count_i = '0;
    logic              stall_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [63:0]       config_frame_o;
    logic              config_valid_o;
    logic [CTX_AW-1:0] ctx_idx_o;
    logic              busy_o;
    logic              done_o;
    logic              wr_err_o;

    cgra_cfg_sequencer #(
        .FRAME_W   (64),
        .CTX_DEPTH (CTX_DEPTH),
        .CTX_AW    (CTX_AW),
        .LOOP_W    (LOOP_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en_i        (wr_en_i),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .start_i        (start_i),
        .ctx_count_i    (ctx_count_i),
        .loop_count_i   (loop_count_i),
        .stall_i        (stall_i),
        .abort_i        (abort_i),
        .config_frame_o (config_frame_o),
        .config_valid_o (config_valid_o),
        .ctx_idx_o      (ctx_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .wr_err_o       (wr_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]       frame;
        logic [CTX_AW-1:0] idx;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [CTX_DEPTH];
    int          total = 0;
    int          bad = 0;
    logic [31:0] vBits, dBits, bBits;
    logic [63:0] fHist [32];

    // Every issued frame is popped and compared against the expected slot contents.
    always @(negedge clk) begin
        if (rst_n && config_valid_o) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected: got frame=%h idx=%0d, required no valid frame", config_frame_o, ctx_idx_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({config_frame_o, ctx_idx_o} !== {e.frame, e.idx}) begin
                    bad++;
                    $display("[TB] FAIL sb_frame: got frame=%h idx=%0d, required frame=%h idx=%0d", config_frame_o, ctx_idx_o, e.frame, e.idx);
                end
            end
        end
    end

    function automatic logic [63:0] mkFrame(logic [5:0] op, int slot);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[OP_HI:OP_LO] = op;
        f[63:56] = slot[7:0];
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadSlot(input int a, input logic [63:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a[CTX_AW-1:0];
        wr_data_i = d;
        step();
        wr_en_i = 1'b0;
        model[a] = d;
    endtask

    task automatic pushRun(input int len, input int loops);
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i < len; i++) begin
                sb.push_back({model[i], i[CTX_AW-1:0]});
            end
        end
    endtask

    task automatic kickStart(input int cnt, input int loops);
        start_i      = 1'b1;
        ctx_count_i  = cnt[CTX_AW:0];
        loop_count_i = loops[LOOP_W-1:0];
        step();
        start_i = 1'b0;
    endtask

    // Records n cycles of outputs; bit k of each mask drives stall/abort for the edge after cycle k.
    task automatic observe(input int n, input logic [31:0] stallMask, input logic [31:0] abortMask);
        vBits = '0;
        dBits = '0;
        bBits = '0;
        for (int k = 0; k < n; k++) begin
            vBits[k] = config_valid_o;
            dBits[k] = done_o;
            bBits[k] = busy_o;
            fHist[k] = config_frame_o;
            stall_i  = stallMask[k];
            abort_i  = abortMask[k];
            step();
        end
        stall_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int c;
        c = 0;
        while ((busy_o || done_o) && c < budget) begin
            step();
            c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $display("[TB] FAIL %s_timeout: got still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({config_frame_o, config_valid_o, ctx_idx_o, busy_o, done_o, wr_err_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got frame=%h v=%b idx=%0d busy=%b done=%b err=%b, required all zero",
                     config_frame_o, config_valid_o, ctx_idx_o, busy_o, done_o, wr_err_o);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        loadSlot(0, mkFrame(OP_ADD, 0));
        loadSlot(1, mkFrame(OP_MUL, 1));
        loadSlot(2, mkFrame(OP_PASS0, 2));
        pushRun(3, 0);
        kickStart(3, 0);
        observe(6, '0, '0);
        total++;
        if (vBits !== 32'b111) begin bad++; $display("[TB] FAIL basic_valid: got %b, required %b", vBits, 32'b111); end
        total++;
        if (dBits !== 32'b1000) begin bad++; $display("[TB] FAIL basic_done: got %b, required %b", dBits, 32'b1000); end
        total++;
        if (bBits !== 32'b111) begin bad++; $display("[TB] FAIL basic_busy: got %b, required %b", bBits, 32'b111); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL basic_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_loops();
        pushRun(2, 2);
        kickStart(2, 2);
        observe(8, '0, '0);
        total++;
        if (vBits !== 32'h3F) begin bad++; $display("[TB] FAIL loops_valid: got %h, required %h", vBits, 32'h3F); end
        total++;
        if (dBits !== 32'h40) begin bad++; $display("[TB] FAIL loops_done: got %h, required %h", dBits, 32'h40); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL loops_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_stall();
        pushRun(2, 2);
        kickStart(2, 2);
        observe(10, 32'b11, '0);
        total++;
        if (vBits !== 32'hF9) begin bad++; $display("[TB] FAIL stall_valid: got %h, required %h", vBits, 32'hF9); end
        total++;
        if (dBits !== 32'h100) begin bad++; $display("[TB] FAIL stall_done: got %h, required %h", dBits, 32'h100); end
        total++;
        if (fHist[2] !== model[0]) begin bad++; $display("[TB] FAIL stall_hold: got %h, required %h", fHist[2], model[0]); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL stall_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_abort();
        for (int i = 3; i < CTX_DEPTH; i++) loadSlot(i, mkFrame(OP_ADD, i));
        pushRun(3, 0);
        kickStart(16, 0);
        observe(8, '0, 32'b100);
        total++;
        if (vBits !== 32'b111) begin bad++; $display("[TB] FAIL abort_valid: got %b, required %b", vBits, 32'b111); end
        total++;
        if (bBits !== 32'b111) begin bad++; $display("[TB] FAIL abort_busy: got %b, required %b", bBits, 32'b111); end
        total++;
        if (dBits !== '0) begin bad++; $display("[TB] FAIL abort_done: got %b, required 0", dBits); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL abort_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_zero_count();
        kickStart(0, 0);
        observe(4, '0, '0);
        total++;
        if (vBits !== '0) begin bad++; $display("[TB] FAIL zero_valid: got %b, required 0", vBits); end
        total++;
        if (dBits !== 32'b1) begin bad++; $display("[TB] FAIL zero_done: got %b, required %b", dBits, 32'b1); end
        total++;
        if (bBits !== '0) begin bad++; $display("[TB] FAIL zero_busy: got %b, required 0", bBits); end
    endtask

    task automatic test_wr_err();
        pushRun(4, 0);
        kickStart(4, 0);
        wr_en_i   = 1'b1;
        wr_addr_i = 4'd1;
        wr_data_i = ~model[1];
        step();
        wr_en_i = 1'b0;
        total++;
        if (wr_err_o !== 1'b1) begin bad++; $display("[TB] FAIL wrerr_pulse: got %b, required 1", wr_err_o); end
        step();
        total++;
        if (wr_err_o !== 1'b0) begin bad++; $display("[TB] FAIL wrerr_clear: got %b, required 0", wr_err_o); end
        waitIdle(20, "wrerr_run1");
        pushRun(2, 0);
        kickStart(2, 0);
        waitIdle(20, "wrerr_run2");
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL wrerr_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_write_with_start();
        logic [63:0] nd;
        nd = mkFrame(OP_PASS0, 0);
        nd[ROUTE_HI:ROUTE_LO] = 4'b1111;
        nd[IMM_HI:IMM_LO]     = 16'hABCD;
        wr_en_i   = 1'b1;
        wr_addr_i = '0;
        wr_data_i = nd;
        model[0]  = nd;
        sb.push_back({nd, 4'd0});
        kickStart(1, 0);
        wr_en_i = 1'b0;
        total++;
        if (wr_err_o !== 1'b0) begin bad++; $display("[TB] FAIL wstart_err: got %b, required 0", wr_err_o); end
        observe(3, '0, '0);
        total++;
        if (vBits !== 32'b1) begin bad++; $display("[TB] FAIL wstart_valid: got %b, required %b", vBits, 32'b1); end
        total++;
        if (dBits !== 32'b10) begin bad++; $display("[TB] FAIL wstart_done: got %b, required %b", dBits, 32'b10); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL wstart_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_overflow();
        pushRun(16, 0);
        kickStart(20, 0);
        observe(20, '0, '0);
        total++;
        if (vBits !== 32'hFFFF) begin bad++; $display("[TB] FAIL overflow_valid: got %h, required %h", vBits, 32'hFFFF); end
        total++;
        if (dBits !== 32'h10000) begin bad++; $display("[TB] FAIL overflow_done: got %h, required %h", dBits, 32'h10000); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL overflow_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        pushRun(1, 3);
        kickStart(1, 3);
        observe(6, '0, '0);
        total++;
        if (vBits !== 32'hF) begin bad++; $display("[TB] FAIL b2b_valid: got %h, required %h", vBits, 32'hF); end
        total++;
        if (dBits !== 32'h10) begin bad++; $display("[TB] FAIL b2b_done: got %h, required %h", dBits, 32'h10); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("[TB] FAIL b2b_sb_left: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_midrun();
        pushRun(16, 0);
        kickStart(16, 0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({config_frame_o, config_valid_o, ctx_idx_o, busy_o, done_o, wr_err_o} !== '0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs: got frame=%h v=%b idx=%0d busy=%b done=%b, required all zero",
                     config_frame_o, config_valid_o, ctx_idx_o, busy_o, done_o);
        end
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if ({config_valid_o, busy_o, done_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL midrst_after: got v=%b busy=%b done=%b, required 000", config_valid_o, busy_o, done_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loops();
        test_stall();
        test_abort();
        test_zero_count();
        test_wr_err();
        test_write_with_start();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
